// File: rtl/ocr_frame_sequencer_pkg.sv
// Shared encodings and constants for the OCR frame sequencer.
// Result bytes are ASCII digits; out-of-range classes map to '?'.
package ocr_frame_sequencer_pkg;

    localparam logic [2:0] ST_WAIT_FRAME  = 3'd0;
    localparam logic [2:0] ST_START_INFER = 3'd1;
    localparam logic [2:0] ST_WAIT_INFER  = 3'd2;
    localparam logic [2:0] ST_SEND        = 3'd3;
    localparam logic [2:0] ST_WAIT_TX     = 3'd4;
    localparam logic [2:0] ST_CLEAR       = 3'd5;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_ERR   = 8'h3F;
    localparam int         FRAME_BYTES = 98;
    localparam logic [3:0] MAX_CLASS   = 4'd9;

    function automatic logic [7:0] class_to_ascii(input logic [3:0] cls);
        return (cls <= MAX_CLASS) ? (ASCII_ZERO + {4'd0, cls}) : ASCII_ERR;
    endfunction

endpackage

// File: rtl/ocr_frame_sequencer_idle_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and
// flags expiry on the cycle that completes LIMIT idle clocks.
module ocr_idle_timer #(
    parameter int LIMIT = 100
) (
    input  logic i_Clock,
    input  logic i_Rst_L,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int             CW   = $clog2(LIMIT + 1);
    localparam logic [CW-1:0]  LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L)
            count <= '0;
        else if (clear || !enable)
            count <= '0;
        else if (count != LAST)
            count <= count + 1'b1;
    end

    assign expire = enable && !clear && (count == LAST);

endmodule

// File: rtl/ocr_frame_sequencer.sv
// Sequences one OCR frame: collector full -> inference -> UART result -> re-arm.
// Define FRAME_TIMEOUT_EN to abort partial frames after TIMEOUT_CLKS idle clocks.
module ocr_frame_sequencer
    import ocr_frame_sequencer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5209,
    parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
    input  logic        i_Clock,
    input  logic        i_Rst_L,
    input  logic        i_RX_DV,
    input  logic        i_Data_Ready,
    output logic        o_Collector_Clr,
    output logic        o_Infer_Start,
    input  logic        i_Infer_Done,
    input  logic [3:0]  i_Infer_Class,
    output logic        o_TX_DV,
    output logic [7:0]  o_TX_Byte,
    input  logic        i_TX_Done,
    output logic        o_Busy,
    output logic [15:0] o_Frame_Count,
    output logic        o_Error
);

    logic [2:0]  state;
    logic        ready_hold;
    logic [15:0] frame_cnt;
    logic        timeout;

`ifdef FRAME_TIMEOUT_EN
    // armed once a byte of a new frame has arrived; dropped whenever we leave WAIT_FRAME
    logic armed;
    logic rx_in_wait;
    logic expire;

    assign rx_in_wait = i_RX_DV && (state == ST_WAIT_FRAME);

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L)
            armed <= 1'b0;
        else if (state != ST_WAIT_FRAME)
            armed <= 1'b0;
        else if (rx_in_wait)
            armed <= 1'b1;
    end

    ocr_idle_timer #(.LIMIT(TIMEOUT_CLKS)) u_idle_timer (
        .i_Clock (i_Clock),
        .i_Rst_L (i_Rst_L),
        .clear   (rx_in_wait),
        .enable  (armed && (state == ST_WAIT_FRAME)),
        .expire  (expire)
    );

    assign timeout = expire && !i_Data_Ready;
`else
    logic unused_rx_dv;
    assign unused_rx_dv = i_RX_DV;
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state           <= ST_WAIT_FRAME;
            ready_hold      <= 1'b0;
            o_Collector_Clr <= 1'b0;
            o_Infer_Start   <= 1'b0;
            o_TX_DV         <= 1'b0;
            o_TX_Byte       <= 8'h00;
            frame_cnt       <= 16'h0000;
            o_Error         <= 1'b0;
        end else begin
            o_Collector_Clr <= 1'b0;
            o_Infer_Start   <= 1'b0;
            o_TX_DV         <= 1'b0;
            ready_hold      <= 1'b0;
            case (state)
                ST_WAIT_FRAME: begin
                    // ready_hold masks the stale flag while the collector clears
                    if (i_Data_Ready && !ready_hold) begin
                        state <= ST_START_INFER;
                    end else if (timeout) begin
                        o_Error         <= 1'b1;
                        o_Collector_Clr <= 1'b1;
                        state           <= ST_CLEAR;
                    end
                end
                ST_START_INFER: begin
                    o_Infer_Start <= 1'b1;
                    state         <= ST_WAIT_INFER;
                end
                ST_WAIT_INFER: begin
                    if (i_Infer_Done) begin
                        o_TX_Byte <= class_to_ascii(i_Infer_Class);
                        if (i_Infer_Class > MAX_CLASS)
                            o_Error <= 1'b1;
                        o_TX_DV <= 1'b1;
                        state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    state <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (i_TX_Done) begin
                        frame_cnt       <= frame_cnt + 16'd1;
                        o_Collector_Clr <= 1'b1;
                        state           <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    ready_hold <= 1'b1;
                    state      <= ST_WAIT_FRAME;
                end
                default: state <= ST_WAIT_FRAME;
            endcase
        end
    end

    assign o_Busy        = (state != ST_WAIT_FRAME);
    assign o_Frame_Count = frame_cnt;

endmodule

// File: tb/tb_ocr_frame_sequencer.sv
// Randomized frame-level bench for ocr_frame_sequencer against a transaction model.
`timescale 1ns/1ps
module tb_ocr_frame_sequencer;

    localparam int TO_CLKS = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_dv = 1'b0, data_ready = 1'b0, infer_done = 1'b0, tx_done = 1'b0;
    logic [3:0]  infer_class = 4'd0;
    logic        clr, infer_start, tx_dv, busy, error;
    logic [7:0]  tx_byte;
    logic [15:0] frame_count;

    int n_chk = 0, n_err = 0;
    int n_start = 0, n_txdv = 0, n_clr = 0;

    // reference model: frames completed, sticky error, last result byte
    logic [15:0] exp_count = 16'd0;
    logic        exp_error = 1'b0;
    logic [7:0]  exp_byte  = 8'h00;

    always #5 clk = ~clk;

    ocr_frame_sequencer #(.CLKS_PER_BIT(5), .TIMEOUT_CLKS(TO_CLKS)) dut (
        .i_Clock         (clk),
        .i_Rst_L         (rst_n),
        .i_RX_DV         (rx_dv),
        .i_Data_Ready    (data_ready),
        .o_Collector_Clr (clr),
        .o_Infer_Start   (infer_start),
        .i_Infer_Done    (infer_done),
        .i_Infer_Class   (infer_class),
        .o_TX_DV         (tx_dv),
        .o_TX_Byte       (tx_byte),
        .i_TX_Done       (tx_done),
        .o_Busy          (busy),
        .o_Frame_Count   (frame_count),
        .o_Error         (error)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (infer_start) n_start++;
            if (tx_dv)       n_txdv++;
            if (clr)         n_clr++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"},  error, exp_error);
        chk({tag, "_cnt"},  frame_count, exp_count);
        chk({tag, "_byte"}, tx_byte, exp_byte);
    endtask

    // one complete frame; late_drop keeps Data_Ready high one extra cycle after the clear
    task automatic run_frame(input logic [3:0] cls, input int infer_lat, input int tx_lat,
                             input bit late_drop);
        int cyc, s0, t0, c0;
        s0 = n_start; t0 = n_txdv; c0 = n_clr;
        data_ready = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!infer_start && cyc < 20);
        chk("start_lat", cyc - 1, 2);
        chk("busy_mid", busy, 1);
        repeat (infer_lat) @(posedge clk);
        tick(); infer_done = 1'b1; infer_class = cls;
        tick(); infer_done = 1'b0;
        exp_byte = (cls <= 4'd9) ? (8'h30 + {4'd0, cls}) : 8'h3F;
        if (cls > 4'd9) exp_error = 1'b1;
        @(negedge clk);
        chk("txdv_lat", tx_dv, 1);
        chk("tx_byte", tx_byte, exp_byte);
        @(negedge clk);
        chk("txdv_once", tx_dv, 0);
        chk("byte_hold", tx_byte, exp_byte);
        repeat (tx_lat) @(posedge clk);
        tick(); tx_done = 1'b1; rx_dv = 1'b1;
        tick(); tx_done = 1'b0; rx_dv = 1'b0;
        exp_count = exp_count + 16'd1;
        @(negedge clk);
        chk("clr_pulse", clr, 1);
        chk("frame_cnt", frame_count, exp_count);
        tick();
        if (late_drop) tick();
        data_ready = 1'b0;
        repeat (3) tick();
        chk("n_start", n_start - s0, 1);
        chk("n_txdv", n_txdv - t0, 1);
        chk("n_clr", n_clr - c0, 1);
        chk_idle("post");
    endtask

    // done/tx-done/rx strobes while idle must not move anything
    task automatic spurious();
        int s0, t0, c0;
        s0 = n_start; t0 = n_txdv; c0 = n_clr;
        tick(); infer_done = 1'b1; infer_class = 4'($urandom_range(0, 15));
        tick(); infer_done = 1'b0; tx_done = 1'b1;
        tick(); tx_done = 1'b0; rx_dv = 1'b1;
        tick(); rx_dv = 1'b0;
        repeat (2) tick();
        chk("spur_pulses", (n_start - s0) + (n_txdv - t0) + (n_clr - c0), 0);
        chk_idle("spur");
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_clr", clr, 0);
        chk("rst_start", infer_start, 0);
        chk("rst_txdv", tx_dv, 0);
        chk_idle("rst");
        tick(); rst_n = 1'b1;
        repeat (2) tick();

        run_frame(4'd7, 0, 0, 1'b0);
        chk("good_err", error, 0);
        run_frame(4'd12, 1, 2, 1'b0);
        chk("bad_err", error, 1);
        run_frame(4'd3, 0, 1, 1'b1);
        chk("err_sticky", error, 1);
        spurious();

        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 2) == 0) spurious();
            run_frame(4'($urandom_range(0, 15)), $urandom_range(0, 4),
                      $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        // reset while waiting on inference
        data_ready = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!infer_start && cyc < 20);
        chk("mid_start", infer_start, 1);
        #1 rst_n = 1'b0;
        exp_count = 16'd0; exp_error = 1'b0; exp_byte = 8'h00;
        @(negedge clk);
        chk("mid_rst_start", infer_start, 0);
        chk("mid_rst_txdv", tx_dv, 0);
        chk("mid_rst_clr", clr, 0);
        chk_idle("mid_rst");
        data_ready = 1'b0;
        tick(); infer_done = 1'b1; infer_class = 4'd5;
        tick(); infer_done = 1'b0; rst_n = 1'b1;
        repeat (2) tick();
        chk_idle("after_rst");
        run_frame(4'd5, 2, 0, 1'b0);

        // counter wrap
        tick();
        force dut.frame_cnt = 16'hFFFF;
        tick();
        release dut.frame_cnt;
        exp_count = 16'hFFFF;
        tick();
        chk("preload", frame_count, 16'hFFFF);
        run_frame(4'd9, 0, 0, 1'b0);
        chk("wrap", frame_count, 16'h0000);

        // five bytes then silence
        for (int b = 0; b < 5; b++) begin
            tick(); rx_dv = 1'b1;
            tick(); rx_dv = 1'b0;
            if (b != 4) repeat (3) tick();
        end
        cyc = 0;
        do begin @(posedge clk); @(negedge clk); cyc++; end while (!clr && cyc < 3 * TO_CLKS);
`ifdef FRAME_TIMEOUT_EN
        exp_error = 1'b1;
        chk("timeout_at", cyc, TO_CLKS);
        chk("timeout_clr", clr, 1);
`else
        chk("no_timeout", cyc, 3 * TO_CLKS);
        chk("no_timeout_clr", clr, 0);
`endif
        repeat (3) tick();
        chk_idle("silence");
        run_frame(4'd0, 1, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
